// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    localparam int MUL_W    = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

endpackage

// File: rtl/add.sv
// 32-bit ripple-carry adder; c[i] is the carry into bit i, c[32] the carry out.
module add
    import mul_seq_pkg::*;
(
    input  logic [MUL_W-1:0] x,
    input  logic [MUL_W-1:0] y,
    input  logic             c_in,
    output logic [MUL_W-1:0] z,
    output logic [MUL_W:0]   c
);

    logic [MUL_W-1:0] sum;
    logic [MUL_W:0]   carry;

    // The ripple is computed in one process so the carry chain is a single combinational net.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = c_in;
        for (int i = 0; i < MUL_W; i++) begin
            sum[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end

    assign z = sum;
    assign c = carry;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle 32x32->64 unsigned multiplier: one add per clock over 32 iterations,
// valid/ready on both the operand and result sides.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*MUL_W-1:0]   product,
    output logic                 busy
);

    mul_state_t state_reg;
    mul_state_t state_next;

    logic [MUL_W-1:0]   m_reg;
    logic [MUL_W-1:0]   hi_reg;
    logic [MUL_W-1:0]   lo_reg;
    logic [CNT_W-1:0]   cnt;

    logic [MUL_W-1:0]   add_y;
    logic [MUL_W-1:0]   add_z;
    logic [MUL_W:0]     add_c;
    logic [2*MUL_W-1:0] step_next;
    logic               last_iter;
    logic               unused_carries;

    assign add_y = lo_reg[0] ? m_reg : '0;

    add u_add (
        .x    (hi_reg),
        .y    (add_y),
        .c_in (1'b0),
        .z    (add_z),
        .c    (add_c)
    );

    // Only the final carry matters; the internal ripple carries are a by-product.
    assign unused_carries = ^add_c[MUL_W-1:0];

    // Carry-out lands in hi_reg[31]; the multiplier bit just consumed falls off the bottom.
    assign step_next = {add_c[MUL_W], add_z, lo_reg[MUL_W-1:1]};
    assign last_iter = (cnt == CNT_W'(MUL_ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        m_reg  <= a;
                        lo_reg <= b;
                        hi_reg <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    {hi_reg, lo_reg} <= step_next;
                    cnt              <= cnt + 1'b1;
                    if (last_iter) begin
                        product <= step_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq against a scoreboard of reference products.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_results = 0;
    logic [63:0] exp_q[$];

    mul_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operand pair through the IDLE handshake and record the reference product.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit record);
        @(negedge clk);
        check("start_ready_idle", 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        a = av;
        b = bv;
        if (record) exp_q.push_back({32'h0, av} * {32'h0, bv});
        @(negedge clk);
        start_valid = 1'b0;
        check("busy_after_accept", {62'd0, busy, start_ready}, {62'd0, 2'b10});
    endtask

    // Wait for the result, hold it for 'gap' cycles of back-pressure, then consume it.
    task automatic finish_op(input int gap, input bit inject);
        int lat = 0;
        logic [63:0] e;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd32);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        n_results++;
        check("product", product, e);
        res_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (inject && i == 3) begin
                start_valid = 1'b1;
                a = 32'd7;
                b = 32'd7;
            end
            @(negedge clk);
            start_valid = 1'b0;
            check("stall_flags", {61'd0, res_valid, start_ready, busy}, {61'd0, 3'b101});
            check("stall_product", product, e);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_ack", {61'd0, res_valid, start_ready, busy}, {61'd0, 3'b010});
    endtask

    initial begin
        rst_n       = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = '0;
        b           = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_product", product, 64'd0);
        check("reset_flags", {61'd0, res_valid, start_ready, busy}, {61'd0, 3'b010});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(32'd3, 32'd5, 1'b1);
        finish_op(0, 1'b0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_op(0, 1'b0);

        issue(32'd0, 32'h1234_5678, 1'b1);
        finish_op(1, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b1);
        finish_op(0, 1'b0);

        // Back-pressure with an ignored start pulse in the middle of DONE.
        issue(32'h8000_0000, 32'd2, 1'b1);
        finish_op(10, 1'b1);
        @(negedge clk);
        check("no_ghost_op", {62'd0, busy, res_valid}, 64'd0);

        // Asynchronous reset mid-iteration, then a clean operation.
        issue(32'd100, 32'd200, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", product, 64'd0);
        check("abort_flags", {61'd0, res_valid, start_ready, busy}, {61'd0, 3'b010});
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd9, 32'd9, 1'b1);
        finish_op(0, 1'b0);

        for (int k = 0; k < 50; k++) begin
            issue($urandom, $urandom, 1'b1);
            finish_op(int'($urandom_range(0, 3)), 1'b0);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("result_count", 64'(n_results), 64'd56);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
